// File: rtl/evt_enc_8to3_pkg.sv
// rtl/evt_enc_8to3_pkg.sv - shared widths and state encoding for the event encoder family
package evt_enc_8to3_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/prio_sel_8to3.sv
// rtl/prio_sel_8to3.sv - combinational priority select over the pending vector
module prio_sel_8to3
    import evt_enc_8to3_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic [N_REQ-1:0]  pending,
    output logic [CODE_W-1:0] sel,
    output logic              any
);

    // Later assignments overwrite earlier ones, so the scan direction sets the winner.
    always_comb begin
        sel = '0;
        any = |pending;
        if (PRIO_MSB) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pending[i]) sel = CODE_W'(i);
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (pending[i]) sel = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/evt_enc_8to3.sv
// rtl/evt_enc_8to3.sv - sequential 8-to-3 event encoder with pending capture and valid/ready output
module evt_enc_8to3
    import evt_enc_8to3_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              out_ready,
    input  logic              ovf_clr,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic [N_REQ-1:0]  pending,
    output logic              ovf
);

    state_t             state;
    state_t             state_next;
    logic [N_REQ-1:0]   pend_q;
    logic [N_REQ-1:0]   clr_mask;
    logic [N_REQ-1:0]   pend_kept;
    logic [CODE_W-1:0]  sel;
    logic [CODE_W-1:0]  code_q;
    logic               any;
    logic               load;
    logic               ovf_q;

    prio_sel_8to3 #(
        .PRIO_MSB (PRIO_MSB)
    ) u_prio_sel (
        .pending (pend_q),
        .sel     (sel),
        .any     (any)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    load       = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (any) load = 1'b1;
                    else     state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The loaded bit is cleared first, so a same-cycle request sets it again.
    always_comb begin
        clr_mask  = load ? (N_REQ'(1) << sel) : '0;
        pend_kept = pend_q & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pend_q <= '0;
            code_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_next;
            pend_q <= pend_kept | req;
            if (load) code_q <= sel;
            ovf_q  <= (|(req & pend_kept)) | (ovf_q & ~ovf_clr);
        end
    end

    assign out_valid = (state == ST_HOLD);
    assign out_code  = code_q;
    assign pending   = pend_q;
    assign ovf       = ovf_q;

endmodule
